// File: rtl/mem_arb_defs_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e : FSM state encodings (IDLE / fetch outstanding / data outstanding)
//   ARB_FULL_BE : all-ones byte-enable source; slice to the port's BE width
package mem_arb_defs_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_e;

  localparam logic [63:0] ARB_FULL_BE = '1;

endpackage

// File: rtl/arb_stat_counter.sv
// Enable-incrementing 32-bit event counter, wraps on overflow.
//   CLK   : clock, rising edge
//   RSTn  : async active-low reset, clears count
//   inc   : count this cycle
//   count : running total
module arb_stat_counter (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)    count <= '0;
    else if (inc) count <= count + 32'd1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF-stage fetch and the MEM-stage
// load/store path. One transaction at a time over a req/ack handshake.
// Ports:
//   CLK, RSTn                          clock / async active-low reset
//   if_req/if_addr/if_kill             fetch request, redirect discard
//   if_valid/if_rdata/if_stall         fetch result pulse, data, stall
//   d_req/d_we/d_be/d_addr/d_wdata     load/store request
//   d_valid/d_rdata/d_stall            completion pulse, load data (held), stall
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   registered memory request
//   mem_ack/mem_rdata                  memory acknowledge + read data
//   err_timeout                        one-cycle pulse when a request is aborted
// Build option: define ARB_STATS_EN to add stat_if_grants, stat_d_grants and
// stat_stall_cycles (32-bit wrapping counters).
module mem_port_arbiter
  import mem_arb_defs_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_kill,
  output logic            if_valid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err_timeout
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]     stat_if_grants,
  output logic [31:0]     stat_d_grants,
  output logic [31:0]     stat_stall_cycles
`endif
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;

  arb_state_e    state, state_nxt;
  grant_t        gnt;
  logic [SW-1:0] streak;
  logic          starved, drop, tmo_reach;
  logic          go_i, go_d, done, tmo_hit;

  assign starved = (streak >= SW'(STARVE_LIMIT));

  // Every completion or abort passes through IDLE, which yields the mandatory
  // one-cycle gap before the next mem_req. Arbitration there sees raw request
  // levels, so a requester that keeps its req high is served again.
  always_comb begin
    state_nxt = state;
    go_i      = 1'b0;
    go_d      = 1'b0;
    done      = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_req && (!if_req || !starved)) begin
          go_d      = 1'b1;
          state_nxt = ARB_DBUSY;
        end else if (if_req) begin
          go_i      = 1'b1;
          state_nxt = ARB_IBUSY;
        end
      end
      ARB_IBUSY, ARB_DBUSY: begin
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = ARB_IDLE;
        end else if (tmo_reach) begin
          tmo_hit   = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // A data grant with a waiting fetch can only happen below the limit, so the
  // increment saturates at STARVE_LIMIT without an explicit clamp.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                streak <= '0;
    else if (go_i)            streak <= '0;
    else if (go_d && if_req)  streak <= streak + SW'(1);
  end

  // Busy-cycle counter; cleared while idle so each grant starts from zero.
  if (TIMEOUT > 0) begin : g_tmo
    logic [TW-1:0] tcnt;
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)                  tcnt <= '0;
      else if (state == ARB_IDLE) tcnt <= '0;
      else                        tcnt <= tcnt + TW'(1);
    end
    assign tmo_reach = (tcnt == TW'(TIMEOUT - 1));
  end else begin : g_no_tmo
    assign tmo_reach = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mem_req     <= 1'b0;
      gnt         <= '0;
      drop        <= 1'b0;
      if_valid    <= 1'b0;
      if_rdata    <= '0;
      d_valid     <= 1'b0;
      d_rdata     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if_valid    <= 1'b0;
      d_valid     <= 1'b0;
      err_timeout <= 1'b0;
      if (go_d) begin
        mem_req <= 1'b1;
        drop    <= 1'b0;
        gnt     <= '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
      end else if (go_i) begin
        mem_req <= 1'b1;
        drop    <= 1'b0;
        gnt     <= '{we: 1'b0, be: ARB_FULL_BE[BW-1:0], addr: if_addr, wdata: '0};
      end
      if (state == ARB_IBUSY && if_kill) drop <= 1'b1;
      if (done) begin
        mem_req <= 1'b0;
        if (state == ARB_DBUSY) begin
          d_valid <= 1'b1;
          d_rdata <= mem_rdata;
        end else if (!drop && !if_kill) begin
          // A kill on the ack cycle itself also discards the fetch.
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
      if (tmo_hit) begin
        mem_req     <= 1'b0;
        err_timeout <= 1'b1;
      end
    end
  end

  assign mem_we    = gnt.we;
  assign mem_be    = gnt.be;
  assign mem_addr  = gnt.addr;
  assign mem_wdata = gnt.wdata;

  // Gated by RSTn so every output reads 0 while reset is held.
  assign if_stall = RSTn & if_req & ~if_valid;
  assign d_stall  = RSTn & d_req  & ~d_valid;

`ifdef ARB_STATS_EN
  logic [2:0]       stat_inc;
  logic [2:0][31:0] stat_cnt;
  assign stat_inc = {if_stall | d_stall, go_d, go_i};
  for (genvar g = 0; g < 3; g++) begin : g_stat
    arb_stat_counter u_cnt (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .inc   (stat_inc[g]),
      .count (stat_cnt[g])
    );
  end
  assign stat_if_grants    = stat_cnt[0];
  assign stat_d_grants     = stat_cnt[1];
  assign stat_stall_cycles = stat_cnt[2];
`endif

endmodule
